// File: rtl/bs_turn_sequencer_if.sv
// Board-side signal bundle of the two-player Battleship turn sequencer.
// The master drives buttons and switches; the slave (sequencer) drives game state.
interface bs_turn_sequencer_if #(
   parameter int N = 10
);
   logic         btn_load;
   logic         btn_fire_a;
   logic         btn_fire_b;
   logic [N-1:0] sw_a;
   logic [N-1:0] sw_b;
   logic [N-1:0] fleet_a;
   logic [N-1:0] fleet_b;
   logic [N-1:0] shots_a;
   logic [N-1:0] shots_b;
   logic         hit;
   logic         turn_a;
   logic         game_over;
   logic         winner_a;
   logic [2:0]   disp_a;
   logic [2:0]   disp_b;

   modport master (
      output btn_load, btn_fire_a, btn_fire_b, sw_a, sw_b,
      input  fleet_a, fleet_b, shots_a, shots_b, hit, turn_a,
             game_over, winner_a, disp_a, disp_b
   );

   modport slave (
      input  btn_load, btn_fire_a, btn_fire_b, sw_a, sw_b,
      output fleet_a, fleet_b, shots_a, shots_b, hit, turn_a,
             game_over, winner_a, disp_a, disp_b
   );
endinterface

// File: rtl/bs_turn_sequencer.sv
// Two-player turn sequencer for 10-cell Battleship: owns fleets and shot histories,
// validates single new-cell shots, holds each result for RESULT_CYC cycles, drives Words2.
module bs_turn_sequencer #(
   parameter int N          = 10,
   parameter int RESULT_CYC = 4
) (
   input  logic                  clk,
   input  logic                  clr_n,
   bs_turn_sequencer_if.slave    bus
);

   localparam int CW = (RESULT_CYC > 1) ? $clog2(RESULT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(RESULT_CYC - 1);
   localparam logic [N-1:0]  ONE      = N'(1);

   localparam logic [2:0] S_SETUP  = 3'd0;
   localparam logic [2:0] S_TURN_A = 3'd1;
   localparam logic [2:0] S_RES_A  = 3'd2;
   localparam logic [2:0] S_TURN_B = 3'd3;
   localparam logic [2:0] S_RES_B  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [2:0] WORD_SETUP = 3'd0;
   localparam logic [2:0] WORD_TURN  = 3'd1;
   localparam logic [2:0] WORD_WAIT  = 3'd2;
   localparam logic [2:0] WORD_HIT   = 3'd3;
   localparam logic [2:0] WORD_MISS  = 3'd4;
   localparam logic [2:0] WORD_BAD   = 3'd5;
   localparam logic [2:0] WORD_WIN   = 3'd6;
   localparam logic [2:0] WORD_LOSE  = 3'd7;

   logic [2:0]    r_state;
   logic [N-1:0]  r_fleet_a;
   logic [N-1:0]  r_fleet_b;
   logic [N-1:0]  r_shots_a;
   logic [N-1:0]  r_shots_b;
   logic          r_bad;
   logic          r_hit_l;
   logic          r_hit;
   logic          r_winner_a;
   logic [CW-1:0] r_cnt;
   logic          r_load_q;
   logic          r_fire_a_q;
   logic          r_fire_b_q;

   logic          w_load_ev;
   logic          w_fire_a_ev;
   logic          w_fire_b_ev;
   logic          w_valid_a;
   logic          w_valid_b;
   logic          w_hit_a;
   logic          w_hit_b;
   logic          w_load_ok;
   logic [2:0]    w_disp_a;
   logic [2:0]    w_disp_b;

   // Button history resets high so a button held through reset cannot fire.
   assign w_load_ev   = bus.btn_load   & ~r_load_q;
   assign w_fire_a_ev = bus.btn_fire_a & ~r_fire_a_q;
   assign w_fire_b_ev = bus.btn_fire_b & ~r_fire_b_q;

   // A shot is exactly one bit set, on a cell the shooter has not fired on before.
   assign w_valid_a = (bus.sw_a != '0) && ((bus.sw_a & (bus.sw_a - ONE)) == '0)
                      && ((bus.sw_a & r_shots_a) == '0);
   assign w_valid_b = (bus.sw_b != '0) && ((bus.sw_b & (bus.sw_b - ONE)) == '0)
                      && ((bus.sw_b & r_shots_b) == '0);

   assign w_hit_a   = |(bus.sw_a & r_fleet_b);
   assign w_hit_b   = |(bus.sw_b & r_fleet_a);
   assign w_load_ok = (bus.sw_a != '0) && (bus.sw_b != '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state    <= S_SETUP;
         r_fleet_a  <= '0;
         r_fleet_b  <= '0;
         r_shots_a  <= '0;
         r_shots_b  <= '0;
         r_bad      <= 1'b0;
         r_hit_l    <= 1'b0;
         r_hit      <= 1'b0;
         r_winner_a <= 1'b0;
         r_cnt      <= '0;
         r_load_q   <= 1'b1;
         r_fire_a_q <= 1'b1;
         r_fire_b_q <= 1'b1;
      end else begin
         r_load_q   <= bus.btn_load;
         r_fire_a_q <= bus.btn_fire_a;
         r_fire_b_q <= bus.btn_fire_b;
         r_hit      <= 1'b0;

         case (r_state)
            S_SETUP: begin
               if (w_load_ev) begin
                  if (w_load_ok) begin
                     r_fleet_a <= bus.sw_a;
                     r_fleet_b <= bus.sw_b;
                     r_shots_a <= '0;
                     r_shots_b <= '0;
                     r_bad     <= 1'b0;
                     r_state   <= S_TURN_A;
                  end else begin
                     r_bad <= 1'b1;
                  end
               end
            end

            S_TURN_A: begin
               if (w_fire_a_ev) begin
                  if (w_valid_a) begin
                     r_shots_a <= r_shots_a | bus.sw_a;
                     r_fleet_b <= r_fleet_b & ~bus.sw_a;
                     r_hit     <= w_hit_a;
                     r_hit_l   <= w_hit_a;
                     r_bad     <= 1'b0;
                     r_cnt     <= CNT_LOAD;
                     r_state   <= S_RES_A;
                  end else begin
                     r_bad <= 1'b1;
                  end
               end
            end

            S_RES_A: begin
               if (r_cnt == '0) begin
                  if (r_fleet_b == '0) begin
                     r_winner_a <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_state <= S_TURN_B;
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end

            S_TURN_B: begin
               if (w_fire_b_ev) begin
                  if (w_valid_b) begin
                     r_shots_b <= r_shots_b | bus.sw_b;
                     r_fleet_a <= r_fleet_a & ~bus.sw_b;
                     r_hit     <= w_hit_b;
                     r_hit_l   <= w_hit_b;
                     r_bad     <= 1'b0;
                     r_cnt     <= CNT_LOAD;
                     r_state   <= S_RES_B;
                  end else begin
                     r_bad <= 1'b1;
                  end
               end
            end

            S_RES_B: begin
               if (r_cnt == '0) begin
                  if (r_fleet_a == '0) begin
                     r_winner_a <= 1'b0;
                     r_state    <= S_DONE;
                  end else begin
                     r_state <= S_TURN_A;
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end

            S_DONE: begin
               if (w_load_ev) begin
                  r_state <= S_SETUP;
               end
            end

            default: r_state <= S_SETUP;
         endcase
      end
   end

   // NOTE: both words get a default before the case so no latch is inferred.
   always_comb begin
      w_disp_a = WORD_SETUP;
      w_disp_b = WORD_SETUP;
      case (r_state)
         S_SETUP: begin
            w_disp_a = r_bad ? WORD_BAD : WORD_SETUP;
            w_disp_b = r_bad ? WORD_BAD : WORD_SETUP;
         end
         S_TURN_A: begin
            w_disp_a = r_bad ? WORD_BAD : WORD_TURN;
            w_disp_b = WORD_WAIT;
         end
         S_RES_A: begin
            w_disp_a = r_hit_l ? WORD_HIT : WORD_MISS;
            w_disp_b = WORD_WAIT;
         end
         S_TURN_B: begin
            w_disp_a = WORD_WAIT;
            w_disp_b = r_bad ? WORD_BAD : WORD_TURN;
         end
         S_RES_B: begin
            w_disp_a = WORD_WAIT;
            w_disp_b = r_hit_l ? WORD_HIT : WORD_MISS;
         end
         S_DONE: begin
            w_disp_a = r_winner_a ? WORD_WIN  : WORD_LOSE;
            w_disp_b = r_winner_a ? WORD_LOSE : WORD_WIN;
         end
         default: begin
            w_disp_a = WORD_SETUP;
            w_disp_b = WORD_SETUP;
         end
      endcase
   end

   assign bus.fleet_a   = r_fleet_a;
   assign bus.fleet_b   = r_fleet_b;
   assign bus.shots_a   = r_shots_a;
   assign bus.shots_b   = r_shots_b;
   assign bus.hit       = r_hit;
   assign bus.turn_a    = (r_state == S_TURN_A);
   assign bus.game_over = (r_state == S_DONE);
   assign bus.winner_a  = r_winner_a;
   assign bus.disp_a    = w_disp_a;
   assign bus.disp_b    = w_disp_b;

endmodule

// File: tb/tb_bs_turn_sequencer.sv
// Self-checking bench for bs_turn_sequencer: directed game walk-through plus random
// play, compared against a game-level model (phases, fleets, shots) kept here.
module tb_bs_turn_sequencer;

   localparam int N  = 10;
   localparam int RC = 4;

   localparam int W_SETUP = 0, W_TURN = 1, W_WAIT = 2, W_HIT = 3;
   localparam int W_MISS  = 4, W_BAD  = 5, W_WIN  = 6, W_LOSE = 7;

   typedef enum {PH_SETUP, PH_A, PH_B, PH_DONE} phase_t;

   logic clk = 1'b0;
   logic clr_n = 1'b0;
   always #5 clk = ~clk;

   bs_turn_sequencer_if #(.N(N)) bus ();

   bs_turn_sequencer #(.N(N), .RESULT_CYC(RC)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   // Game-level reference model.
   phase_t       m_phase;
   logic [N-1:0] m_fleet_a, m_fleet_b, m_shots_a, m_shots_b;
   bit           m_bad, m_win_a;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic m_reset();
      m_phase   = PH_SETUP;
      m_fleet_a = '0;
      m_fleet_b = '0;
      m_shots_a = '0;
      m_shots_b = '0;
      m_bad     = 0;
      m_win_a   = 0;
   endtask

   task automatic check_vectors(input string tag);
      check({tag, ".fleet_a"}, 32'(bus.fleet_a), 32'(m_fleet_a));
      check({tag, ".fleet_b"}, 32'(bus.fleet_b), 32'(m_fleet_b));
      check({tag, ".shots_a"}, 32'(bus.shots_a), 32'(m_shots_a));
      check({tag, ".shots_b"}, 32'(bus.shots_b), 32'(m_shots_b));
   endtask

   // Compare all outputs against a non-result phase of the model.
   task automatic check_idle(input string tag);
      int ea, eb, et, eg;
      ea = W_SETUP; eb = W_SETUP; et = 0; eg = 0;
      case (m_phase)
         PH_SETUP: begin ea = m_bad ? W_BAD : W_SETUP; eb = ea; end
         PH_A:     begin ea = m_bad ? W_BAD : W_TURN; eb = W_WAIT; et = 1; end
         PH_B:     begin ea = W_WAIT; eb = m_bad ? W_BAD : W_TURN; end
         PH_DONE:  begin ea = m_win_a ? W_WIN : W_LOSE; eb = m_win_a ? W_LOSE : W_WIN; eg = 1; end
         default:  ;
      endcase
      check({tag, ".disp_a"},    32'(bus.disp_a),    32'(ea));
      check({tag, ".disp_b"},    32'(bus.disp_b),    32'(eb));
      check({tag, ".turn_a"},    32'(bus.turn_a),    32'(et));
      check({tag, ".game_over"}, 32'(bus.game_over), 32'(eg));
      check({tag, ".hit"},       32'(bus.hit),       32'(0));
      check_vectors(tag);
      if (m_phase == PH_DONE) check({tag, ".winner_a"}, 32'(bus.winner_a), 32'(m_win_a));
   endtask

   task automatic press(input bit l, input bit fa, input bit fb);
      bus.btn_load   = l;
      bus.btn_fire_a = fa;
      bus.btn_fire_b = fb;
      step();
      bus.btn_load   = 1'b0;
      bus.btn_fire_a = 1'b0;
      bus.btn_fire_b = 1'b0;
   endtask

   task automatic do_load(input logic [N-1:0] a, input logic [N-1:0] b);
      bus.sw_a = a;
      bus.sw_b = b;
      press(1, 0, 0);
      if (m_phase == PH_SETUP) begin
         if (a != '0 && b != '0) begin
            m_fleet_a = a; m_fleet_b = b;
            m_shots_a = '0; m_shots_b = '0;
            m_bad = 0; m_phase = PH_A;
         end else begin
            m_bad = 1;
         end
      end else if (m_phase == PH_DONE) begin
         m_phase = PH_SETUP;
      end
      check_idle("load");
      step();
      check_idle("load_hold");
   endtask

   task automatic do_fire(input bit fa, input bit fb, input logic [N-1:0] a, input logic [N-1:0] b);
      bit           shooter_a, acts, is_hit;
      logic [N-1:0] s;
      bus.sw_a = a;
      bus.sw_b = b;
      press(0, fa, fb);
      shooter_a = (m_phase == PH_A);
      acts = (m_phase == PH_A && fa) || (m_phase == PH_B && fb);
      s = shooter_a ? a : b;
      if (!acts) begin
         check_idle("fire_ignored");
         step();
         check_idle("fire_ignored_hold");
         return;
      end
      if ($countones(s) != 1 || (s & (shooter_a ? m_shots_a : m_shots_b)) != '0) begin
         m_bad = 1;
         check_idle("fire_bad");
         step();
         check_idle("fire_bad_hold");
         return;
      end
      if (shooter_a) begin
         is_hit = (s & m_fleet_b) != '0;
         m_shots_a |= s; m_fleet_b &= ~s;
      end else begin
         is_hit = (s & m_fleet_a) != '0;
         m_shots_b |= s; m_fleet_a &= ~s;
      end
      m_bad = 0;
      for (int k = 0; k < RC; k++) begin
         check("res.hit", 32'(bus.hit), 32'(k == 0 ? is_hit : 1'b0));
         check("res.disp_shooter", 32'(shooter_a ? bus.disp_a : bus.disp_b),
               32'(is_hit ? W_HIT : W_MISS));
         check("res.disp_other", 32'(shooter_a ? bus.disp_b : bus.disp_a), 32'(W_WAIT));
         check("res.turn_a", 32'(bus.turn_a), 32'(0));
         check("res.game_over", 32'(bus.game_over), 32'(0));
         check_vectors("res");
         // Button noise inside the result window must be ignored.
         if (k < RC - 1) begin
            bus.btn_load   = 1'($urandom);
            bus.btn_fire_a = 1'($urandom);
            bus.btn_fire_b = 1'($urandom);
         end else begin
            bus.btn_load = 1'b0; bus.btn_fire_a = 1'b0; bus.btn_fire_b = 1'b0;
         end
         step();
      end
      if (shooter_a) begin
         if (m_fleet_b == '0) begin m_phase = PH_DONE; m_win_a = 1; end
         else m_phase = PH_B;
      end else begin
         if (m_fleet_a == '0) begin m_phase = PH_DONE; m_win_a = 0; end
         else m_phase = PH_A;
      end
      check_idle("after_res");
   endtask

   task automatic async_reset(input string tag);
      clr_n = 1'b0;
      #2;
      m_reset();
      check_idle(tag);
      step();
      clr_n = 1'b1;
      step();
      check_idle({tag, "_released"});
   endtask

   function automatic logic [N-1:0] rand_target(input logic [N-1:0] shots);
      logic [N-1:0] v;
      int c, i;
      v = '0;
      c = int'($urandom_range(0, 9));
      if (c < 7 && shots != '1) begin
         i = int'($urandom_range(0, N - 1));
         while (shots[i]) i = (i + 1) % N;
         v[i] = 1'b1;
      end else if (c < 9) begin
         v[$urandom_range(0, N - 1)] = 1'b1;
      end else begin
         v = N'($urandom);
      end
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] la, lb;
      int who;

      // Buttons held through reset with legal switches must not start a game.
      m_reset();
      bus.btn_load = 1'b1; bus.btn_fire_a = 1'b1; bus.btn_fire_b = 1'b0;
      bus.sw_a = 10'h003; bus.sw_b = 10'h300;
      step(); step();
      check_idle("in_reset");
      clr_n = 1'b1;
      step(); step();
      check_idle("held_after_reset");
      check("reset.disp_a", 32'(bus.disp_a), 32'(W_SETUP));
      bus.btn_load = 1'b0; bus.btn_fire_a = 1'b0;
      step();
      check_idle("released_buttons");

      // Directed walk-through of one game.
      do_load(10'h003, 10'h000);
      check("bad_load.disp_b", 32'(bus.disp_b), 32'(W_BAD));
      do_load(10'h003, 10'h300);
      check("load.fleet_b", 32'(bus.fleet_b), 32'h300);
      do_fire(1, 0, 10'h100, 10'h000);
      check("a_hit.fleet_b", 32'(bus.fleet_b), 32'h200);
      check("a_hit.disp_b_turn", 32'(bus.disp_b), 32'(W_TURN));
      do_fire(0, 1, 10'h000, 10'h081);
      check("b_two_bits.disp_b", 32'(bus.disp_b), 32'(W_BAD));
      do_fire(0, 1, 10'h000, 10'h080);
      check("b_miss.turn_a", 32'(bus.turn_a), 32'(1));
      do_fire(1, 0, 10'h100, 10'h000);
      check("a_refire.disp_a", 32'(bus.disp_a), 32'(W_BAD));
      do_fire(1, 0, 10'h200, 10'h000);
      check("a_wins.winner_a", 32'(bus.winner_a), 32'(1));
      check("a_wins.disp_b", 32'(bus.disp_b), 32'(W_LOSE));
      do_fire(1, 1, 10'h001, 10'h002);
      do_load(10'h0F0, 10'h00F);
      check("restart.game_over", 32'(bus.game_over), 32'(0));

      // Off-turn and simultaneous fire, then reset mid RES_B.
      do_load(10'h0F0, 10'h00F);
      do_fire(0, 1, 10'h000, 10'h001);
      do_fire(1, 1, 10'h001, 10'h010);
      check("simul.shots_b", 32'(bus.shots_b), 32'h000);
      bus.sw_b = 10'h020;
      press(0, 0, 1);
      check("res_b.hit", 32'(bus.hit), 32'(1));
      step();
      async_reset("rst_mid_res_b");

      // Random play.
      for (int it = 0; it < 400; it++) begin
         who = int'($urandom_range(0, 99));
         if (who < 2) begin
            async_reset("rand_reset");
         end else if (who < 12 || ((m_phase == PH_SETUP || m_phase == PH_DONE) && who < 60)) begin
            la = N'($urandom); lb = N'($urandom);
            if ($urandom_range(0, 9) == 0) la = '0;
            if ($urandom_range(0, 9) == 0) lb = '0;
            do_load(la, lb);
         end else if (who < 16) begin
            step();
            check_idle("rand_idle");
         end else begin
            la = rand_target(m_shots_a);
            lb = rand_target(m_shots_b);
            case ($urandom_range(0, 3))
               0:       do_fire(1, 1, la, lb);
               1:       do_fire(1, 0, la, lb);
               2:       do_fire(0, 1, la, lb);
               default: do_fire(m_phase == PH_A, m_phase == PH_B, la, lb);
            endcase
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bs_turn_sequencer.md
# bs_turn_sequencer

Two-player turn sequencer for the 10-cell Battleship game. It owns both fleet registers and both shot-history registers, and gates the attack buttons so only the player on turn can fire. It rejects shots that are not exactly one new cell, applies hits to the opposing fleet, and shows each result for a fixed time. It drives the per-player status word select for the seven-segment `Words2` display and reports game over and the winner.

## Interface
Parameters:
- `N`, 10, number of grid cells (bits per fleet/shot vector)
- `RESULT_CYC`, 4, cycles the HIT/MISS word is held after a valid shot (≥1; board build overrides to ~50_000_000)

Ports:
- `clk` in 1: system clock; all state updates on its rising edge
- `clr_n` in 1: reset, asynchronous, active-low
- `btn_load` in 1: load/restart button (both players' BTN1 ANDed upstream, already synchronized)
- `btn_fire_a` in 1: player A fire button (synchronized)
- `btn_fire_b` in 1: player B fire button (synchronized)
- `sw_a` in N: player A switches (ship placement in SETUP, target in A's turn)
- `sw_b` in N: player B switches (same use for B)
- `fleet_a` out N: A's surviving ship cells
- `fleet_b` out N: B's surviving ship cells
- `shots_a` out N: cells A has fired on
- `shots_b` out N: cells B has fired on
- `hit` out 1: one-cycle pulse when a valid shot hits
- `turn_a` out 1: 1 while player A is to move (TURN_A)
- `game_over` out 1: 1 in DONE
- `winner_a` out 1: valid in DONE; 1 = A won
- `disp_a` out 3: `Words2` word select for player A
- `disp_b` out 3: `Words2` word select for player B

## Operation
- Word codes: 0 SETUP, 1 YOUR_TURN, 2 WAIT, 3 HIT, 4 MISS, 5 BAD, 6 WIN, 7 LOSE.
- Button edge detection:
  - Each button has a previous-sample register, reset to 1. A button held through reset does not fire.
  - An event is `btn & ~btn_q`.
  - Events in states that do not use that button are discarded.
- States: SETUP, TURN_A, RES_A, TURN_B, RES_B, DONE.
- SETUP:
  - `disp_a`/`disp_b` = 0, or 5 if `bad` is set.
  - On a load event with `sw_a != 0` and `sw_b != 0`: `fleet_a<=sw_a`, `fleet_b<=sw_b`, `shots_a<=0`, `shots_b<=0`, `bad<=0`, go to TURN_A.
  - On a load event with either switch vector zero: `bad<=1`, stay in SETUP.
- TURN_A:
  - Display: A=1 (or 5 if `bad`), B=2.
  - A shot is valid iff `popcount(sw_a)==1` and `(sw_a & shots_a)==0`.
  - Valid fire_a event:
    - `shots_a|=sw_a`, `fleet_b&=~sw_a`.
    - `hit` pulses iff `(sw_a & fleet_b)!=0`; a `hit_l` latch records hit/miss.
    - `bad<=0`, counter loaded with RESULT_CYC-1, go to RES_A.
  - Invalid fire_a event: `bad<=1`, registers unchanged, stay in TURN_A.
- RES_A:
  - Display: A = 3 if `hit_l`, else 4; B=2.
  - The counter decrements each cycle. At 0:
    - `fleet_b==0`: go to DONE with `winner_a=1`.
    - Otherwise: go to TURN_B.
- TURN_B and RES_B mirror TURN_A and RES_A with the roles of A and B swapped. In DONE after B's shot, `winner_a=0`.
- DONE:
  - Winner's display = 6, loser's = 7. `game_over=1`.
  - Load event: go to SETUP. Fleets and shots are held until the next successful load.
- Load events outside SETUP and DONE are ignored.
- Fire events outside the owning TURN state are ignored, including all fire events during RES_*.
- `turn_a` = (state==TURN_A).

## Timing
- Reset (async, `clr_n`=0):
  - State SETUP; fleets, shots, `bad`, `hit_l`, counter, `winner_a` = 0.
  - `hit`=0, `turn_a`=0, `game_over`=0, `disp_a`=`disp_b`=0, button registers = 1.
- Reset release is sampled synchronously; the first action is possible at the first edge after release.
- Event latency: the register and state update happen at the first rising edge that samples the button high after it was sampled low.
- `hit` is registered: high for exactly the one cycle following that edge, which is the first RES cycle.
- RES_* lasts exactly RESULT_CYC cycles. The TURN_* at the edge after the last RES cycle is the next state.
- `disp_*`, `turn_a`, `game_over`, `winner_a` are decoded from registered state; each is valid in the same cycle as the state.
- Shots on the last remaining ship cell: the fleet clears at the fire edge. DONE is entered after RES (the shooter sees HIT first).
- Simultaneous `btn_fire_a` and `btn_fire_b` events: only the player on turn acts; the other edge is consumed (no deferred fire).
- Reset mid-game, in any state: immediate return to reset values; there is no partial update.

## Test plan
- Reset with `btn_fire_a` held high, then release reset -> no event; SETUP, disp 0/0, all vectors 0.
- Load with `sw_a=10'h003`, `sw_b=0` -> `bad`, disp 5/5, still SETUP. Then `sw_b=10'h300` and load -> `fleet_a=003`, `fleet_b=300`, TURN_A, disp 1/2.
- A fires `sw_a=10'h100` -> `hit` one cycle, `fleet_b=200`, `shots_a=100`, disp_a=3 for 4 cycles, then TURN_B, disp 2/1.
- B fires `sw_b=10'h081` (2 bits) -> disp_b=5, state unchanged. B fires `sw_b=10'h080` -> miss, disp_b=4 for 4 cycles, then TURN_A.
- A refires `10'h100` -> BAD. A fires `10'h200` -> hit, `fleet_b=0`; after 4 cycles: DONE, `winner_a=1`, disp 6/7. Fire events in DONE are ignored; load -> SETUP.
- `btn_fire_b` pulsed during TURN_A and RES_A -> no register change. `clr_n` pulsed low mid RES_B -> all outputs return to reset values asynchronously.
